// File: rtl/pe_conv_sequencer_pkg.sv
// Shared definitions for the convolution PE control path: the sequencer state
// encoding and the default datapath widths.
package pe_ctrl_pkg;

  localparam int FILT_ADDR_LEN_DEF = 4;
  localparam int IF_ADDR_LEN_DEF   = 5;
  localparam int NF_LEN_DEF        = 3;
  localparam int WIN_CNT_LEN_DEF   = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_ARM    = 3'd2,
    ST_RUN    = 3'd3,
    ST_NEXT   = 3'd4,
    ST_FINISH = 3'd5,
    ST_ABORT  = 3'd6
  } pe_state_e;

  // States in which an abort request is honoured.
  function automatic logic abortable(pe_state_e s);
    return (s != ST_IDLE) && (s != ST_ABORT);
  endfunction

endpackage

// File: rtl/pe_conv_sequencer_if.sv
// Job + datapath handshake bundle for pe_conv_sequencer.
//   master: job issuer / datapath side (drives start, abort, cfg_*, *_done)
//   slave : the sequencer (drives reader pulses, mux selects, status)
interface pe_conv_sequencer_if #(
  parameter int FILT_ADDR_LEN = 4,
  parameter int IF_ADDR_LEN   = 5,
  parameter int NF_LEN        = 3,
  parameter int WIN_CNT_LEN   = 8
) ();

  logic                     start;
  logic                     abort;
  logic [FILT_ADDR_LEN-1:0] cfg_filt_len;
  logic [IF_ADDR_LEN-1:0]   cfg_stride_len;
  logic [NF_LEN-1:0]        cfg_num_filt;
  logic                     cfg_psum_in;
  logic                     full_done;
  logic                     psum_done;

  logic                     IF_read_start;
  logic                     filter_read_start;
  logic                     start_rd_gen;
  logic                     regs_clr;
  logic                     IF_mux_sel;
  logic                     filter_mux_sel;
  logic                     reset_accumulation;
  logic                     accumulate_input_psum;
  logic [FILT_ADDR_LEN-1:0] filt_len;
  logic [IF_ADDR_LEN-1:0]   stride_len;
  logic [NF_LEN-1:0]        filt_idx;
  logic [WIN_CNT_LEN-1:0]   win_cnt;
  logic                     busy;
  logic                     done;

  modport master (
    output start, abort, cfg_filt_len, cfg_stride_len, cfg_num_filt,
           cfg_psum_in, full_done, psum_done,
    input  IF_read_start, filter_read_start, start_rd_gen, regs_clr,
           IF_mux_sel, filter_mux_sel, reset_accumulation,
           accumulate_input_psum, filt_len, stride_len, filt_idx, win_cnt,
           busy, done
  );

  modport slave (
    input  start, abort, cfg_filt_len, cfg_stride_len, cfg_num_filt,
           cfg_psum_in, full_done, psum_done,
    output IF_read_start, filter_read_start, start_rd_gen, regs_clr,
           IF_mux_sel, filter_mux_sel, reset_accumulation,
           accumulate_input_psum, filt_len, stride_len, filt_idx, win_cnt,
           busy, done
  );

endinterface

// File: rtl/pe_conv_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear (clear has priority).
//   clk_i, rst_i : clock, async active-high reset
//   clr_i        : zero the count
//   inc_i        : add one unless already all-ones
//   cnt_o        : registered count
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pe_conv_sequencer.sv
// Control FSM for one convolution PE: latches a job config, pulses the
// readers / address generator, steers the scratchpad and psum muxes and runs
// one IF pass per filter.
//   clk, rst : clock, async active-high reset
//   seq_if   : job inputs, datapath events and all control/status outputs
//
// state  | meaning
// IDLE   | waiting for start, config latched on start
// LOAD   | pulse IF/filter readers and clear datapath regs
// ARM    | pulse read-address generator
// RUN    | stream IF, count output windows until full_done
// NEXT   | advance filter base, clear regs, bump filt_idx
// FINISH | one-cycle done pulse
// ABORT  | one-cycle regs_clr after cancel
module pe_conv_sequencer
  import pe_ctrl_pkg::*;
#(
  parameter int FILT_ADDR_LEN = FILT_ADDR_LEN_DEF,
  parameter int IF_ADDR_LEN   = IF_ADDR_LEN_DEF,
  parameter int NF_LEN        = NF_LEN_DEF,
  parameter int WIN_CNT_LEN   = WIN_CNT_LEN_DEF
) (
  input  logic                clk,
  input  logic                rst,
  pe_conv_sequencer_if.slave  seq_if
);

  pe_state_e                state_q, state_d;
  logic [NF_LEN-1:0]        filt_idx_q, filt_idx_d;
  logic [NF_LEN-1:0]        num_filt_q;
  logic [FILT_ADDR_LEN-1:0] filt_len_q;
  logic [IF_ADDR_LEN-1:0]   stride_len_q;
  logic                     psum_in_q, psum_in_d;
  logic                     accept;
  logic                     win_clr, win_inc;
  logic                     last_pass;

  logic if_read_start_q, filter_read_start_q, start_rd_gen_q, regs_clr_q;
  logic if_mux_sel_q, filter_mux_sel_q, reset_acc_q, acc_in_psum_q;
  logic busy_q, done_q;

  assign last_pass = (filt_idx_q == (num_filt_q - NF_LEN'(1)));
  assign psum_in_d = accept ? seq_if.cfg_psum_in : psum_in_q;

  always_comb begin
    state_d    = state_q;
    filt_idx_d = filt_idx_q;
    accept     = 1'b0;
    win_clr    = 1'b0;
    win_inc    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (seq_if.start) begin
          state_d    = ST_LOAD;
          filt_idx_d = '0;
          accept     = 1'b1;
          win_clr    = 1'b1;
        end
      end
      ST_LOAD:   state_d = ST_ARM;
      ST_ARM:    state_d = ST_RUN;
      ST_RUN: begin
        // A window reported together with full_done is still counted.
        win_inc = seq_if.psum_done;
        if (seq_if.full_done) begin
          state_d = last_pass ? ST_FINISH : ST_NEXT;
        end
      end
      ST_NEXT: begin
        state_d    = ST_ARM;
        filt_idx_d = filt_idx_q + NF_LEN'(1);
        win_clr    = 1'b1;
      end
      ST_FINISH: state_d = ST_IDLE;
      ST_ABORT:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (seq_if.abort && abortable(state_q)) begin
      state_d    = ST_ABORT;
      filt_idx_d = filt_idx_q;
      win_clr    = 1'b0;
      win_inc    = 1'b0;
    end
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q             <= ST_IDLE;
      filt_idx_q          <= '0;
      num_filt_q          <= '0;
      filt_len_q          <= '0;
      stride_len_q        <= '0;
      psum_in_q           <= 1'b0;
      if_read_start_q     <= 1'b0;
      filter_read_start_q <= 1'b0;
      start_rd_gen_q      <= 1'b0;
      regs_clr_q          <= 1'b0;
      if_mux_sel_q        <= 1'b0;
      filter_mux_sel_q    <= 1'b0;
      reset_acc_q         <= 1'b0;
      acc_in_psum_q       <= 1'b0;
      busy_q              <= 1'b0;
      done_q              <= 1'b0;
    end else begin
      state_q    <= state_d;
      filt_idx_q <= filt_idx_d;
      psum_in_q  <= psum_in_d;
      if (accept) begin
        filt_len_q   <= seq_if.cfg_filt_len;
        stride_len_q <= seq_if.cfg_stride_len;
        // Zero filters still means one pass.
        num_filt_q   <= (seq_if.cfg_num_filt == '0) ? NF_LEN'(1)
                                                    : seq_if.cfg_num_filt;
      end
      if_read_start_q     <= (state_d == ST_LOAD);
      filter_read_start_q <= (state_d == ST_LOAD);
      start_rd_gen_q      <= (state_d == ST_ARM);
      regs_clr_q          <= (state_d inside {ST_LOAD, ST_NEXT, ST_ABORT});
      if_mux_sel_q        <= (state_d inside {ST_ARM, ST_RUN});
      filter_mux_sel_q    <= (state_d == ST_NEXT);
      done_q              <= (state_d == ST_FINISH);
      busy_q              <= (state_d != ST_IDLE);
      reset_acc_q         <= (state_d != ST_IDLE) && (filt_idx_d != '0);
      acc_in_psum_q       <= psum_in_d && (state_d != ST_IDLE) &&
                             (filt_idx_d == '0);
    end
  end

  sat_counter #(.WIDTH(WIN_CNT_LEN)) u_win_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (win_clr),
    .inc_i (win_inc),
    .cnt_o (seq_if.win_cnt)
  );

  assign seq_if.IF_read_start         = if_read_start_q;
  assign seq_if.filter_read_start     = filter_read_start_q;
  assign seq_if.start_rd_gen          = start_rd_gen_q;
  assign seq_if.regs_clr              = regs_clr_q;
  assign seq_if.IF_mux_sel            = if_mux_sel_q;
  assign seq_if.filter_mux_sel        = filter_mux_sel_q;
  assign seq_if.reset_accumulation    = reset_acc_q;
  assign seq_if.accumulate_input_psum = acc_in_psum_q;
  assign seq_if.filt_len              = filt_len_q;
  assign seq_if.stride_len            = stride_len_q;
  assign seq_if.filt_idx              = filt_idx_q;
  assign seq_if.busy                  = busy_q;
  assign seq_if.done                  = done_q;

endmodule

// File: tb/tb_pe_conv_sequencer.sv
module tb_pe_conv_sequencer;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   c_rdgen, c_fmux, c_clr, c_done;

  pe_conv_sequencer_if bus ();

  pe_conv_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .seq_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_mon();
    step();
    c_rdgen += int'(bus.start_rd_gen);
    c_fmux  += int'(bus.filter_mux_sel);
    c_clr   += int'(bus.regs_clr);
    c_done  += int'(bus.done);
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.abort = 0; bus.full_done = 0; bus.psum_done = 0;
  endtask

  task automatic set_cfg(input int fl, input int sl, input int nf, input bit pin);
    bus.cfg_filt_len   = 4'(fl);
    bus.cfg_stride_len = 5'(sl);
    bus.cfg_num_filt   = 3'(nf);
    bus.cfg_psum_in    = pin;
  endtask

  // Launch a job and stop with the FSM in RUN (pass 0).
  task automatic go_to_run();
    bus.start = 1; step(); bus.start = 0;
    step(); step();
  endtask

  task automatic test_reset();
    idle_inputs();
    set_cfg(0, 0, 0, 0);
    rst = 1;
    step(); step();
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %0b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %0b want 0", bus.done); end
    n_cmp++; if (bus.win_cnt !== 8'd0) begin n_bad++; $display("FAIL rst_win_cnt: got %0d want 0", bus.win_cnt); end
    n_cmp++; if ({bus.IF_read_start, bus.filter_read_start, bus.start_rd_gen, bus.regs_clr,
                  bus.IF_mux_sel, bus.filter_mux_sel, bus.reset_accumulation,
                  bus.accumulate_input_psum} !== 8'd0) begin
      n_bad++; $display("FAIL rst_pulses: some control output nonzero");
    end
    rst = 0;
    step();
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_rel_busy: got %0b want 0", bus.busy); end
  endtask

  task automatic test_single_filter();
    set_cfg(3, 1, 1, 0);
    bus.start = 1; step(); bus.start = 0;
    n_cmp++; if (bus.IF_read_start !== 1'b1) begin n_bad++; $display("FAIL sf_if_rd_start: got %0b want 1", bus.IF_read_start); end
    n_cmp++; if (bus.filter_read_start !== 1'b1) begin n_bad++; $display("FAIL sf_filt_rd_start: got %0b want 1", bus.filter_read_start); end
    n_cmp++; if (bus.regs_clr !== 1'b1) begin n_bad++; $display("FAIL sf_load_clr: got %0b want 1", bus.regs_clr); end
    n_cmp++; if (bus.start_rd_gen !== 1'b0) begin n_bad++; $display("FAIL sf_rdgen_early: got %0b want 0", bus.start_rd_gen); end
    n_cmp++; if (bus.filt_len !== 4'd3) begin n_bad++; $display("FAIL sf_filt_len_load: got %0d want 3", bus.filt_len); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL sf_busy: got %0b want 1", bus.busy); end
    // psum_done in ARM must be ignored
    bus.psum_done = 1;
    step();
    bus.psum_done = 0;
    n_cmp++; if (bus.start_rd_gen !== 1'b1) begin n_bad++; $display("FAIL sf_rdgen: got %0b want 1", bus.start_rd_gen); end
    n_cmp++; if (bus.IF_read_start !== 1'b0) begin n_bad++; $display("FAIL sf_if_rd_once: got %0b want 0", bus.IF_read_start); end
    n_cmp++; if (bus.IF_mux_sel !== 1'b1) begin n_bad++; $display("FAIL sf_if_mux_arm: got %0b want 1", bus.IF_mux_sel); end
    step();
    n_cmp++; if (bus.win_cnt !== 8'd0) begin n_bad++; $display("FAIL sf_win_ignored: got %0d want 0", bus.win_cnt); end
    bus.psum_done = 1;
    repeat (4) step();
    bus.psum_done = 0;
    n_cmp++; if (bus.win_cnt !== 8'd4) begin n_bad++; $display("FAIL sf_win_cnt: got %0d want 4", bus.win_cnt); end
    n_cmp++; if (bus.reset_accumulation !== 1'b0) begin n_bad++; $display("FAIL sf_reset_acc: got %0b want 0", bus.reset_accumulation); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL sf_done_early: got %0b want 0", bus.done); end
    bus.full_done = 1; step(); bus.full_done = 0;
    n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL sf_done: got %0b want 1", bus.done); end
    n_cmp++; if (bus.IF_mux_sel !== 1'b0) begin n_bad++; $display("FAIL sf_if_mux_fin: got %0b want 0", bus.IF_mux_sel); end
    step();
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL sf_done_width: got %0b want 0", bus.done); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL sf_idle: got %0b want 0", bus.busy); end
    n_cmp++; if (bus.win_cnt !== 8'd4) begin n_bad++; $display("FAIL sf_win_hold: got %0d want 4", bus.win_cnt); end
    n_cmp++; if (bus.filt_len !== 4'd3 || bus.stride_len !== 5'd1) begin
      n_bad++; $display("FAIL sf_cfg: got filt_len=%0d stride=%0d want 3/1", bus.filt_len, bus.stride_len);
    end
  endtask

  task automatic test_multi_filter();
    set_cfg(2, 2, 3, 1);
    c_rdgen = 0; c_fmux = 0; c_clr = 0; c_done = 0;
    bus.start = 1; step_mon(); bus.start = 0;
    step_mon(); step_mon();
    n_cmp++; if (bus.accumulate_input_psum !== 1'b1 || bus.reset_accumulation !== 1'b0) begin
      n_bad++; $display("FAIL mf_pass0_acc: got acc_in=%0b reset_acc=%0b want 1/0", bus.accumulate_input_psum, bus.reset_accumulation);
    end
    bus.psum_done = 1; step_mon(); step_mon(); bus.psum_done = 0;
    bus.full_done = 1; step_mon(); bus.full_done = 0;
    n_cmp++; if (bus.filter_mux_sel !== 1'b1 || bus.regs_clr !== 1'b1) begin
      n_bad++; $display("FAIL mf_next: got fmux=%0b clr=%0b want 1/1", bus.filter_mux_sel, bus.regs_clr);
    end
    step_mon(); step_mon();
    n_cmp++; if (bus.filt_idx !== 3'd1 || bus.win_cnt !== 8'd0) begin
      n_bad++; $display("FAIL mf_pass1_idx: got idx=%0d win=%0d want 1/0", bus.filt_idx, bus.win_cnt);
    end
    n_cmp++; if (bus.accumulate_input_psum !== 1'b0 || bus.reset_accumulation !== 1'b1) begin
      n_bad++; $display("FAIL mf_pass1_acc: got acc_in=%0b reset_acc=%0b want 0/1", bus.accumulate_input_psum, bus.reset_accumulation);
    end
    bus.full_done = 1; step_mon(); bus.full_done = 0;
    step_mon(); step_mon();
    n_cmp++; if (bus.filt_idx !== 3'd2 || bus.reset_accumulation !== 1'b1) begin
      n_bad++; $display("FAIL mf_pass2: got idx=%0d reset_acc=%0b want 2/1", bus.filt_idx, bus.reset_accumulation);
    end
    bus.full_done = 1; step_mon(); bus.full_done = 0;
    step_mon(); step_mon();
    n_cmp++; if (c_rdgen !== 3) begin n_bad++; $display("FAIL mf_rdgen_cnt: got %0d want 3", c_rdgen); end
    n_cmp++; if (c_fmux !== 2) begin n_bad++; $display("FAIL mf_fmux_cnt: got %0d want 2", c_fmux); end
    n_cmp++; if (c_clr !== 3) begin n_bad++; $display("FAIL mf_clr_cnt: got %0d want 3", c_clr); end
    n_cmp++; if (c_done !== 1) begin n_bad++; $display("FAIL mf_done_cnt: got %0d want 1", c_done); end
    n_cmp++; if (bus.reset_accumulation !== 1'b0 || bus.accumulate_input_psum !== 1'b0) begin
      n_bad++; $display("FAIL mf_idle_acc: got reset_acc=%0b acc_in=%0b want 0/0", bus.reset_accumulation, bus.accumulate_input_psum);
    end
  endtask

  task automatic test_simultaneous();
    set_cfg(1, 1, 1, 0);
    go_to_run();
    bus.psum_done = 1; bus.full_done = 1; step();
    bus.psum_done = 0; bus.full_done = 0;
    n_cmp++; if (bus.win_cnt !== 8'd1 || bus.done !== 1'b1) begin
      n_bad++; $display("FAIL sim_evt: got win=%0d done=%0b want 1/1", bus.win_cnt, bus.done);
    end
    step();
  endtask

  task automatic test_saturation();
    set_cfg(1, 1, 1, 0);
    go_to_run();
    bus.psum_done = 1;
    repeat (254) step();
    n_cmp++; if (bus.win_cnt !== 8'd254) begin n_bad++; $display("FAIL sat_254: got %0d want 254", bus.win_cnt); end
    repeat (46) step();
    bus.psum_done = 0;
    n_cmp++; if (bus.win_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_255: got %0d want 255", bus.win_cnt); end
    bus.full_done = 1; step(); bus.full_done = 0;
    step();
  endtask

  task automatic test_abort();
    set_cfg(1, 1, 2, 0);
    go_to_run();
    bus.abort = 1; bus.full_done = 1; bus.psum_done = 1; step();
    idle_inputs();
    n_cmp++; if (bus.regs_clr !== 1'b1 || bus.busy !== 1'b1) begin
      n_bad++; $display("FAIL ab_state: got clr=%0b busy=%0b want 1/1", bus.regs_clr, bus.busy);
    end
    n_cmp++; if (bus.filter_mux_sel !== 1'b0 || bus.start_rd_gen !== 1'b0 || bus.done !== 1'b0 || bus.win_cnt !== 8'd0) begin
      n_bad++; $display("FAIL ab_pulses: got fmux=%0b rdgen=%0b done=%0b win=%0d want 0/0/0/0",
                        bus.filter_mux_sel, bus.start_rd_gen, bus.done, bus.win_cnt);
    end
    step();
    n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_bad++; $display("FAIL ab_idle: got busy=%0b done=%0b want 0/0", bus.busy, bus.done);
    end
    bus.abort = 1; step(); bus.abort = 0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL ab_in_idle: got busy=%0b want 0", bus.busy); end
    bus.abort = 1; bus.start = 1; step(); idle_inputs();
    n_cmp++; if (bus.IF_read_start !== 1'b1) begin n_bad++; $display("FAIL ab_start_wins: got %0b want 1", bus.IF_read_start); end
    step(); step();
    bus.full_done = 1; step(); bus.full_done = 0;
    step(); step();
    bus.full_done = 1; step(); bus.full_done = 0;
    n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL ab_job_done: got %0b want 1", bus.done); end
    step();
  endtask

  task automatic test_start_while_busy();
    set_cfg(5, 7, 1, 0);
    bus.start = 1; step();
    set_cfg(9, 2, 4, 1);
    step(); step();
    bus.start = 0;
    n_cmp++; if (bus.filt_len !== 4'd5 || bus.stride_len !== 5'd7) begin
      n_bad++; $display("FAIL swb_cfg: got filt_len=%0d stride=%0d want 5/7", bus.filt_len, bus.stride_len);
    end
    n_cmp++; if (bus.IF_read_start !== 1'b0 || bus.accumulate_input_psum !== 1'b0) begin
      n_bad++; $display("FAIL swb_restart: got if_rd=%0b acc_in=%0b want 0/0", bus.IF_read_start, bus.accumulate_input_psum);
    end
    bus.full_done = 1; step(); bus.full_done = 0;
    n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL swb_done: got %0b want 1", bus.done); end
    step();
    n_cmp++; if (bus.filt_len !== 4'd5) begin n_bad++; $display("FAIL swb_hold: got %0d want 5", bus.filt_len); end
  endtask

  task automatic test_num_filt_zero();
    set_cfg(2, 3, 0, 0);
    go_to_run();
    bus.full_done = 1; step(); bus.full_done = 0;
    n_cmp++; if (bus.done !== 1'b1 || bus.filt_idx !== 3'd0) begin
      n_bad++; $display("FAIL nf0_one_pass: got done=%0b idx=%0d want 1/0", bus.done, bus.filt_idx);
    end
    step();
  endtask

  task automatic test_reset_mid_run();
    set_cfg(6, 4, 2, 1);
    go_to_run();
    bus.psum_done = 1; step(); step(); bus.psum_done = 0;
    #2 rst = 1;
    #1;
    n_cmp++; if (bus.busy !== 1'b0 || bus.IF_mux_sel !== 1'b0 || bus.accumulate_input_psum !== 1'b0) begin
      n_bad++; $display("FAIL rmr_ctrl: got busy=%0b ifmux=%0b acc_in=%0b want 0/0/0", bus.busy, bus.IF_mux_sel, bus.accumulate_input_psum);
    end
    n_cmp++; if (bus.win_cnt !== 8'd0 || bus.filt_len !== 4'd0 || bus.stride_len !== 5'd0) begin
      n_bad++; $display("FAIL rmr_regs: got win=%0d filt_len=%0d stride=%0d want 0/0/0", bus.win_cnt, bus.filt_len, bus.stride_len);
    end
    step();
    rst = 0;
    c_done = 0;
    step_mon(); step_mon(); step_mon();
    n_cmp++; if (bus.busy !== 1'b0 || c_done !== 0) begin
      n_bad++; $display("FAIL rmr_after: got busy=%0b done_pulses=%0d want 0/0", bus.busy, c_done);
    end
  endtask

  initial begin
    test_reset();
    test_single_filter();
    test_multi_filter();
    test_simultaneous();
    test_saturation();
    test_abort();
    test_start_while_busy();
    test_num_filt_zero();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pe_conv_sequencer.md
Name: pe_conv_sequencer

Overview:
- Control FSM for one convolution PE datapath (IF/filter readers, read-address generator, scratchpads, MAC, psum accumulation).
- Latches a job configuration, then issues the reader and address-generator start pulses and the scratchpad/psum mux selects.
- Runs one full IF pass per filter, advancing the filter base between passes, and reports completion.
- Sits between the top-level job interface and the PE datapath.

Parameters:
FILT_ADDR_LEN, 4, filter scratch address width / filter length width
IF_ADDR_LEN, 5, IF scratch address width / stride width
NF_LEN, 3, width of filter-count config and filt_idx
WIN_CNT_LEN, 8, width of per-pass output-window counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  job start pulse; accepted only in IDLE
abort  in  1  cancel current job
cfg_filt_len  in  FILT_ADDR_LEN  filter length for the job
cfg_stride_len  in  IF_ADDR_LEN  stride for the job
cfg_num_filt  in  NF_LEN  number of filter passes; 0 treated as 1
cfg_psum_in  in  1  seed pass 0 with external p_sum_input
full_done  in  1  datapath: IF stream fully consumed for the pass
psum_done  in  1  datapath: one output window written
IF_read_start  out  1  pulse to IF reader
filter_read_start  out  1  pulse to filter reader and filter-size register
start_rd_gen  out  1  pulse to read-address generator
regs_clr  out  1  pulse clearing IF/mult registers and filter dout
IF_mux_sel  out  1  IF raddr mux select: 0 = waddr, 1 = raddr+1
filter_mux_sel  out  1  filter raddr mux select: 1 = raddr+filt_size
reset_accumulation  out  1  psum seed mux select: 0 = zero, 1 = stored psum
accumulate_input_psum  out  1  select external p_sum_input
filt_len  out  FILT_ADDR_LEN  latched cfg_filt_len
stride_len  out  IF_ADDR_LEN  latched cfg_stride_len
filt_idx  out  NF_LEN  current filter pass index
win_cnt  out  WIN_CNT_LEN  windows completed in current pass
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle job-complete pulse

Behaviour:
- Reset: state = IDLE. Every output, counter and config register is 0.
- States and transitions:
  - IDLE: start=1 latches all cfg_* (num_filt 0 becomes 1). Next state LOAD.
  - LOAD (1 cycle): IF_read_start, filter_read_start and regs_clr = 1. filt_idx and win_cnt cleared. filt_len is already valid this cycle. Next state ARM.
  - ARM (1 cycle): start_rd_gen = 1. Next state RUN.
  - RUN: psum_done increments win_cnt, saturating at all-ones. On full_done: if filt_idx == num_filt-1, next state FINISH; otherwise NEXT.
  - NEXT (1 cycle): filter_mux_sel = 1, regs_clr = 1, filt_idx++, win_cnt cleared. Next state ARM.
  - FINISH (1 cycle): done = 1. Next state IDLE. filt_idx and win_cnt hold their final values until the next start.
  - ABORT (1 cycle): regs_clr = 1, all other pulses 0. Next state IDLE.
- Level outputs:
  - IF_mux_sel = 1 in ARM and RUN, else 0.
  - reset_accumulation = 1 when busy and filt_idx != 0, else 0.
  - accumulate_input_psum = latched cfg_psum_in AND busy AND filt_idx == 0.
- All outputs are registered, i.e. decoded from the registered state. Latency from start to IF_read_start is 1 cycle; start to start_rd_gen is 2 cycles.
- Boundary conditions:
  - psum_done and full_done in the same cycle: the window is counted, then the pass ends.
  - full_done or psum_done outside RUN: ignored.
  - start while busy: ignored; latched config is unchanged.
  - abort in any busy state wins over full_done and psum_done and moves to ABORT. abort in IDLE is ignored. abort and start together in IDLE: start wins.
  - Async rst asserted mid-job: immediate return to the reset state, no done pulse.

Decomposition:
- Shared package pe_ctrl_pkg holds the state encoding (IDLE, LOAD, ARM, RUN, NEXT, FINISH, ABORT as a 3-bit enum) and default widths.
- Single module. The filter-pass counter and the window counter are inline.
- Optional sub-module: sat_counter, a parameterised saturating up-counter with clear, used for win_cnt.

Test Plan:
- Reset check: rst=1 mid-RUN -> all outputs 0 in the same cycle; after release the FSM is in IDLE and busy=0.
- Single filter: num_filt=1, filt_len=3, stride=1; start at cycle 0 -> IF_read_start/filter_read_start/regs_clr at cycle 1, start_rd_gen at cycle 2; 4 psum_done pulses then full_done -> win_cnt=4, done 1 cycle after full_done, filt_len=3, stride_len=1.
- Three filters, cfg_psum_in=1 -> accumulate_input_psum=1 only during pass 0; reset_accumulation=0/1/1 for passes 0/1/2; filter_mux_sel and regs_clr pulse once per NEXT (2 pulses total); start_rd_gen pulses 3 times; single done.
- Simultaneous events: psum_done and full_done in the same cycle on the last pass -> win_cnt increments and FINISH follows; 300 psum_done pulses with WIN_CNT_LEN=8 -> win_cnt saturates at 255.
- Abort/ignored start: abort in RUN together with full_done -> ABORT (regs_clr=1), then IDLE, no done; start while busy -> config unchanged; cfg_num_filt=0 -> exactly one pass.
